// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side scheduling blocks.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int DEF_GAP_CYCLES   = 2;
  localparam int DEF_BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_BUSY = 2'b01,
    WAIT_DONE = 2'b10,
    GAP       = 2'b11
  } arb_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from rr_ptr+1,
// wrapping at NUM_REQ-1 so non-power-of-2 counts never visit unused indices.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources: grants round-robin,
// tracks the tx_busy handshake per frame and pulses ack/done/err per requester.
//
// state     | meaning
// IDLE      | arbitrating; grant only when a request is pending and tx_busy is low
// WAIT_BUSY | tx_start issued, waiting for the uart to raise tx_busy
// WAIT_DONE | frame on the line, waiting for tx_busy to fall
// GAP       | forced idle line time before the next arbitration
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             done,
  output logic                           err,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic                           active
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(max_int(GAP_CYCLES, BUSY_TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  arb_state_t             state;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       owner;
  logic [PTR_W-1:0]       winner;
  logic                   win_valid;
  logic [CNT_W-1:0]       cnt;
  logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= PTR_W'(NUM_REQ - 1);
      owner    <= '0;
      cnt      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      ack      <= '0;
      done     <= '0;
      err      <= 1'b0;
      active   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      ack      <= '0;
      done     <= '0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          // a busy line in IDLE is a foreign or stale frame; hold off until it clears
          if (win_valid && !tx_busy) begin
            tx_data     <= req_bytes[winner];
            tx_start    <= 1'b1;
            ack[winner] <= 1'b1;
            owner       <= winner;
            rr_ptr      <= winner;
            cnt         <= '0;
            state       <= WAIT_BUSY;
            active      <= 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == BUSY_LAST) begin
            err   <= 1'b1;
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            done[owner] <= 1'b1;
            cnt         <= '0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              state  <= IDLE;
              active <= 1'b0;
            end
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state  <= IDLE;
            active <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: behavioural uart model plus a
// round-robin reference computed from request masks.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int TMO = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ack, done;
  logic           err, tx_start, active, tx_busy;
  logic [7:0]     tx_data;
  logic           force_en = 1'b0, force_val = 1'b0;

  logic           u_pend = 1'b0, u_busy = 1'b0;
  int             u_left = 0;
  int             frame_len = 4;

  logic [2:0]     req3 = '0;
  logic [23:0]    req_data3 = '0;
  logic [2:0]     ack3, done3;
  logic           err3, tx_start3, active3;
  logic           tx_busy3 = 1'b0;
  logic [7:0]     tx_data3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int exp_ptr  = N - 1;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack), .done(done),
    .err(err), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .active(active)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .GAP_CYCLES(0), .BUSY_TIMEOUT(4)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_data(req_data3), .ack(ack3), .done(done3),
    .err(err3), .tx_start(tx_start3), .tx_data(tx_data3), .tx_busy(tx_busy3), .active(active3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  assign tx_busy = force_en ? force_val : u_busy;

  // uart: busy rises two edges after tx_start goes high and stays up frame_len cycles
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      u_pend <= 1'b0; u_busy <= 1'b0; u_left <= 0;
    end else if (tx_start && !force_en) begin
      u_pend <= 1'b1;
    end else if (u_pend) begin
      u_pend <= 1'b0; u_busy <= 1'b1; u_left <= frame_len - 1;
    end else if (u_busy) begin
      if (u_left == 0) u_busy <= 1'b0;
      else u_left <= u_left - 1;
    end
  end

  function automatic int rr_pick(input logic [7:0] r, input int ptr, input int nreq);
    for (int k = 1; k <= nreq; k++) begin
      if (r[(ptr + k) % nreq]) return (ptr + k) % nreq;
    end
    return -1;
  endfunction

  task automatic wait_start(input int maxc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (tx_start) begin cyc = i; break; end
    end
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (done != '0) begin cyc = i; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req = '0; req3 = '0; force_en = 1'b0; tx_busy3 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_ptr = N - 1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    n_checks++;
    if ({ack, done, err, tx_start, tx_data, active} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {ack, done, err, tx_start, tx_data, active});
    end
    n_checks++;
    if ({ack3, done3, err3, tx_start3, tx_data3, active3} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs3: got %h expected 0", {ack3, done3, err3, tx_start3, tx_data3, active3});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_ptr = N - 1;
  endtask

  task automatic test_single();
    int cyc, t0;
    logic a1, a2;
    frame_len = 5;
    @(negedge clk);
    req_data = {24'h0, 8'hA5};
    req = 4'b0001;
    wait_start(10, cyc);
    t0 = cyc_cnt;
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("FAIL single_latency: got %0d expected 1", cyc); end
    n_checks++;
    if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b expected 0001", ack); end
    n_checks++;
    if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", tx_data); end
    exp_ptr = 0;
    req = '0;
    req_data = '0;
    @(negedge clk);
    n_checks++;
    if ({tx_start, ack} !== 5'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 0", {tx_start, ack}); end
    wait_done(40, cyc);
    n_checks++;
    if (done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b expected 0001", done); end
    n_checks++;
    if (cyc_cnt - t0 !== frame_len + 3) begin
      n_fail++; $display("FAIL single_done_latency: got %0d expected %0d", cyc_cnt - t0, frame_len + 3);
    end
    n_checks++;
    if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data_hold: got %h expected a5", tx_data); end
    @(negedge clk); a1 = active;
    @(negedge clk); a2 = active;
    n_checks++;
    if ({a1, a2} !== 2'b10) begin n_fail++; $display("FAIL single_gap_length: got %b expected 10", {a1, a2}); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] pat [24];
    logic [N-1:0] mask;
    int cyc, exp_w, prev_start, prev_frame;
    do_reset();
    for (int i = 0; i < 24; i++) pat[i] = (i < 5) ? 4'hF : N'($urandom_range(1, 15));
    pat[5] = 4'b1000;
    pat[6] = 4'b1010;
    pat[7] = 4'b1010;
    prev_start = -1;
    prev_frame = 0;
    @(negedge clk);
    req = pat[0];
    req_data = $urandom;
    for (int it = 0; it < 24; it++) begin
      exp_w = rr_pick({4'b0, req}, exp_ptr, N);
      mask = '0;
      mask[exp_w] = 1'b1;
      frame_len = $urandom_range(1, 6);
      wait_start(60, cyc);
      n_checks++;
      if (ack !== mask) begin n_fail++; $display("FAIL rr_ack it=%0d: got %b expected %b", it, ack, mask); end
      n_checks++;
      if (tx_data !== req_data[8*exp_w +: 8]) begin
        n_fail++; $display("FAIL rr_data it=%0d: got %h expected %h", it, tx_data, req_data[8*exp_w +: 8]);
      end
      if (prev_start >= 0) begin
        n_checks++;
        if (cyc_cnt - prev_start < prev_frame + GAP + 2) begin
          n_fail++; $display("FAIL rr_spacing it=%0d: got %0d expected >= %0d", it, cyc_cnt - prev_start, prev_frame + GAP + 2);
        end
      end
      prev_start = cyc_cnt;
      prev_frame = frame_len;
      exp_ptr = exp_w;
      req = (it < 23) ? pat[it + 1] : '0;
      req_data = $urandom;
      @(negedge clk);
      n_checks++;
      if ({tx_start, ack} !== 5'b0) begin n_fail++; $display("FAIL rr_pulse_width it=%0d: got %b expected 0", it, {tx_start, ack}); end
      wait_done(40, cyc);
      n_checks++;
      if (done !== mask) begin n_fail++; $display("FAIL rr_done it=%0d: got %b expected %b", it, done, mask); end
    end
  endtask

  task automatic test_timeout();
    logic [N-1:0] mask;
    int cyc, exp_w, err_cyc;
    logic saw_done;
    @(negedge clk);
    force_en = 1'b1;
    force_val = 1'b0;
    req = 4'b0010;
    req_data = $urandom;
    exp_w = rr_pick({4'b0, req}, exp_ptr, N);
    mask = '0; mask[exp_w] = 1'b1;
    wait_start(20, cyc);
    n_checks++;
    if (ack !== mask) begin n_fail++; $display("FAIL tmo_ack: got %b expected %b", ack, mask); end
    exp_ptr = exp_w;
    saw_done = 1'b0;
    err_cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done != '0) saw_done = 1'b1;
      if (err) begin err_cyc = i; break; end
    end
    n_checks++;
    if (err_cyc !== TMO) begin n_fail++; $display("FAIL tmo_err_cycle: got %0d expected %0d", err_cyc, TMO); end
    @(negedge clk);
    if (done != '0) saw_done = 1'b1;
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_width: got %b expected 0", err); end
    n_checks++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL tmo_no_done: got %b expected 0", saw_done); end
    force_en = 1'b0;
    frame_len = 3;
    exp_w = rr_pick({4'b0, req}, exp_ptr, N);
    mask = '0; mask[exp_w] = 1'b1;
    wait_start(20, cyc);
    n_checks++;
    if (cyc !== GAP) begin n_fail++; $display("FAIL tmo_regrant_delay: got %0d expected %0d", cyc, GAP); end
    n_checks++;
    if (ack !== mask) begin n_fail++; $display("FAIL tmo_regrant_ack: got %b expected %b", ack, mask); end
    exp_ptr = exp_w;
    req = '0;
    wait_done(40, cyc);
    n_checks++;
    if (done !== mask) begin n_fail++; $display("FAIL tmo_regrant_done: got %b expected %b", done, mask); end
  endtask

  task automatic test_busy_idle();
    logic [N-1:0] mask;
    int cyc, exp_w;
    logic saw;
    @(negedge clk);
    force_en = 1'b1;
    force_val = 1'b1;
    req = 4'b0100;
    req_data = $urandom;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (tx_start) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) begin n_fail++; $display("FAIL busy_idle_hold: got %b expected 0", saw); end
    force_en = 1'b0;
    exp_w = rr_pick({4'b0, req}, exp_ptr, N);
    mask = '0; mask[exp_w] = 1'b1;
    wait_start(5, cyc);
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("FAIL busy_idle_release: got %0d expected 1", cyc); end
    n_checks++;
    if (ack !== mask) begin n_fail++; $display("FAIL busy_idle_ack: got %b expected %b", ack, mask); end
    exp_ptr = exp_w;
    req = '0;
    wait_done(40, cyc);
    n_checks++;
    if (done !== mask) begin n_fail++; $display("FAIL busy_idle_done: got %b expected %b", done, mask); end
  endtask

  task automatic test_reset_mid();
    int cyc, exp_w;
    logic [N-1:0] mask;
    frame_len = 8;
    @(negedge clk);
    req = 4'b0001;
    req_data = $urandom;
    wait_start(20, cyc);
    req = '0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({active, tx_busy} !== 2'b11) begin n_fail++; $display("FAIL mid_in_frame: got %b expected 11", {active, tx_busy}); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({ack, done, err, tx_start, tx_data, active} !== '0) begin
      n_fail++; $display("FAIL mid_async_clear: got %h expected 0", {ack, done, err, tx_start, tx_data, active});
    end
    @(negedge clk);
    reset = 1'b1;
    exp_ptr = N - 1;
    req = 4'b1001;
    exp_w = rr_pick({4'b0, req}, exp_ptr, N);
    mask = '0; mask[exp_w] = 1'b1;
    frame_len = 2;
    wait_start(5, cyc);
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("FAIL mid_regrant_latency: got %0d expected 1", cyc); end
    n_checks++;
    if (ack !== mask) begin n_fail++; $display("FAIL mid_regrant_ack: got %b expected %b", ack, mask); end
    exp_ptr = exp_w;
    req = '0;
    wait_done(40, cyc);
    n_checks++;
    if (done !== mask) begin n_fail++; $display("FAIL mid_regrant_done: got %b expected %b", done, mask); end
  endtask

  task automatic test_three_req();
    logic [2:0] pats [3];
    logic [2:0] m3;
    int cyc, ew, p3;
    pats[0] = 3'b100; pats[1] = 3'b101; pats[2] = 3'b101;
    p3 = 2;
    @(negedge clk);
    req3 = pats[0];
    req_data3 = $urandom;
    for (int k = 0; k < 3; k++) begin
      ew = rr_pick({5'b0, req3}, p3, 3);
      m3 = '0; m3[ew] = 1'b1;
      cyc = -1;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (tx_start3) begin cyc = i; break; end
      end
      n_checks++;
      if (cyc !== 1) begin n_fail++; $display("FAIL three_latency k=%0d: got %0d expected 1", k, cyc); end
      n_checks++;
      if (ack3 !== m3) begin n_fail++; $display("FAIL three_ack k=%0d: got %b expected %b", k, ack3, m3); end
      n_checks++;
      if (tx_data3 !== req_data3[8*ew +: 8]) begin
        n_fail++; $display("FAIL three_data k=%0d: got %h expected %h", k, tx_data3, req_data3[8*ew +: 8]);
      end
      p3 = ew;
      req3 = (k < 2) ? pats[k + 1] : 3'b000;
      @(negedge clk);
      tx_busy3 = 1'b1;
      repeat (3) @(negedge clk);
      tx_busy3 = 1'b0;
      cyc = -1;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (done3 != '0) begin cyc = i; break; end
      end
      n_checks++;
      if (done3 !== m3) begin n_fail++; $display("FAIL three_done k=%0d: got %b expected %b", k, done3, m3); end
      n_checks++;
      if (active3 !== 1'b0) begin n_fail++; $display("FAIL three_no_gap k=%0d: got %b expected 0", k, active3); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_busy_idle();
    test_reset_mid();
    test_three_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single UART transmitter among NUM_REQ byte requesters. It picks one pending requester and drives tx_start/tx_data for one cycle. It then tracks the transmitter's tx_busy handshake through the whole frame and reports per-requester acknowledge and completion pulses. It sits between the command/telemetry sources and the uart instance's tx_start/tx_data/tx_busy pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 2, idle cycles forced on the line after each frame before the next grant (0 allowed)
BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after tx_start before declaring a fault (>=3)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low
req  input  NUM_REQ  level request per requester; bit i high = byte pending on req_data slice i
req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i]
ack  output  NUM_REQ  one-cycle pulse: requester i's byte captured, requester may change data/drop req
done  output  NUM_REQ  one-cycle pulse: requester i's frame finished on the line
err  output  1  one-cycle pulse: tx_busy never rose within BUSY_TIMEOUT
tx_start  output  1  to uart tx_start, one-cycle pulse
tx_data  output  8  to uart tx_data, held from grant until next grant
tx_busy  input  1  from uart tx_busy
active  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous, active-low. It forces:
  - state=IDLE, rr_ptr=NUM_REQ-1 so requester 0 wins first.
  - tx_start=0, tx_data=8'h00, ack=0, done=0, err=0, active=0, counters=0.
- All outputs are registered. No combinational path from req or tx_busy to any output.
- States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - Sampled at edge E0 with req!=0: the winner w is the first set bit searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - At E0: tx_data<=req_data[w], tx_start<=1, ack[w]<=1, owner<=w, rr_ptr<=w, cnt<=0, state<=WAIT_BUSY.
  - With req==0: stay in IDLE, all pulses 0.
- WAIT_BUSY:
  - tx_start and ack return to 0 at E1, so each is exactly one cycle wide.
  - cnt increments each cycle.
  - tx_busy==1 -> WAIT_DONE.
  - cnt==BUSY_TIMEOUT-1 with tx_busy still 0 -> err<=1, go to GAP, no done pulse.
  - The uart raises tx_busy 2 cycles after the tx_start edge. The default timeout covers this with margin.
- WAIT_DONE:
  - Waits for tx_busy==0, then done[owner]<=1 for one cycle.
  - With GAP_CYCLES>0: cnt<=0, state<=GAP.
  - With GAP_CYCLES==0: state<=IDLE directly.
- GAP: counts GAP_CYCLES cycles, then IDLE. req is ignored during GAP.
- Arbitration is evaluated only in IDLE, so minimum spacing between tx_start pulses is frame time + GAP_CYCLES + 2.
- A requester holding req high after its ack is re-arbitrated as a new byte. Round robin guarantees any other pending requester is served first.
- req dropping after IDLE sampling has no effect: the byte is already captured.
- tx_busy high while in IDLE (foreign/stale frame): no grant is issued until tx_busy==0.
- tx_busy glitching low then high within WAIT_DONE: the first low sample ends the frame. tx_busy from the uart is registered and glitch-free.
- Reset mid-frame returns to IDLE immediately, with no done or err pulse. The uart's own reset is shared, so its frame also aborts.
- rr_ptr and owner width: $clog2(NUM_REQ). The wrap compares against NUM_REQ-1, not 2^width-1, for non-power-of-2 counts.
- cnt width: $clog2(max(GAP_CYCLES,BUSY_TIMEOUT)+1).

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE=2'b00, WAIT_BUSY=2'b01, WAIT_DONE=2'b10, GAP=2'b11);
  - UART_DATA_W=8;
  - default GAP and timeout constants.
- One sub-module rr_arbiter (combinational): inputs req and rr_ptr; outputs winner index and valid. It is reused later for the rx-side consumer mux.

Test Plan:
1. Single requester: req=4'b0001, data 8'hA5 -> ack[0] and tx_start pulse same cycle, tx_data=8'hA5; with the uart model, done[0] after tx_busy falls, then GAP of 2 cycles.
2. All four requesting continuously -> grant order 0,1,2,3,0; each ack exactly one cycle; no two tx_start pulses closer than frame+4 cycles.
3. Requests 4'b1010 after owner=3 -> next grant to 1, then 3; rr_ptr wrap verified. Repeat with NUM_REQ=3 and req=3'b101 from rr_ptr=2 -> grant 0.
4. tx_busy tied 0 -> err pulse at cycle BUSY_TIMEOUT after tx_start; no done; returns to IDLE after GAP; next request served.
5. tx_busy high at entry to IDLE with req pending -> no tx_start until tx_busy drops; then normal grant.
6. Assert reset (0) while in WAIT_DONE -> all outputs 0 and state IDLE asynchronously; after release, req=4'b0100 -> grant 2 with rr_ptr reset behaviour (search starts at 0).
